ntlm_candidate_scheduler: RTL and testbench
===========================================

// Module: ntlm_candidate_scheduler
// PURPOSE
// - Sequences the printable-candidate chunk generator and dispatches each 512-bit MD5 chunk to one of
//   NUM_CORES hash cores. Dispatch is round-robin over ready cores.
// - Steps the generator only when a candidate is accepted, so no candidate is skipped or duplicated.
// - Detects keyspace exhaustion, drains in-flight work and latches the first core reporting a hit.
// - Sits between the generator and the cracker core array; the host drives start/abort and reads status.
// PARAMETERS
// - NUM_CORES  4   number of hash cores served (1..16)
// - CORE_W     2   index width, $clog2(NUM_CORES), minimum 1
// - CNT_W      48  width of the issued-candidate counter
// PORTS
// - clk          in   1          rising-edge clock
// - reset        in   1          asynchronous, active-high reset
// - start        in   1          pulse: begin a run (honoured in IDLE, DONE, FOUND)
// - abort        in   1          pulse: return to IDLE from any state
// - gen_rst_n    out  1          active-low reset to the generator; 0 holds it at chunk=0
// - gen_step     out  1          generator clock-enable; the generator advances one candidate per cycle high
// - gen_chunk    in   512        generator output (registered inside the generator)
// - core_chunk   out  512        broadcast candidate bus, equals gen_chunk
// - core_valid   out  NUM_CORES  one-hot grant; at most one bit high
// - core_ready   in   NUM_CORES  core can accept a chunk this cycle
// - core_idle    in   NUM_CORES  core has no candidate in flight
// - core_hit     in   NUM_CORES  single-cycle hit pulse from a core
// - busy         out  1          state is PRIME, RUN or DRAIN
// - done         out  1          keyspace exhausted or limit reached, all cores idle, no hit
// - found        out  1          a hit was latched
// - found_core   out  CORE_W     index of the hitting core
// - issued_count out  CNT_W      candidates accepted by cores in the current run
// BEHAVIOUR
// Reset values
// - State=IDLE, gen_rst_n=0, gen_step=0, core_valid=0, busy=done=found=0.
// - found_core=0, issued_count=0, round-robin pointer rr=0.
// States
// - IDLE: gen_rst_n=0. On start: issued_count, rr, done and found clear; go to PRIME.
// - PRIME (1 cycle): gen_rst_n=1, gen_step=1. The generator loads its first candidate; go to RUN.
// - RUN: grant the first set bit of core_ready, searching from rr upward with wrap.
//   - core_valid = grant (combinational from core_ready, state and exhaustion).
//   - A transfer occurs when core_valid&core_ready; then gen_step=1, issued_count+1 (saturating),
//     and rr=(grant+1) mod NUM_CORES.
//   - No ready core: no grant and no step; the generator holds its value.
//   - gen_chunk==0 in RUN means the keyspace is exhausted (the generator wraps to 0 after the last
//     candidate). Suppress the grant that cycle and go to DRAIN.
// - DRAIN: no grants, gen_step=0. When all core_idle bits are high, go to DONE (done=1).
// - DONE / FOUND: outputs hold. start restarts via IDLE clear then PRIME. abort goes to IDLE.
// Hit and abort handling
// - Any core_hit in RUN or DRAIN: go to FOUND next cycle; found=1.
//   - found_core = lowest set index of core_hit.
//   - Grants and steps stop in that same cycle (combinational). Outstanding cores are left running.
// - Hits in any other state are ignored.
// - Priority within one cycle: abort > core_hit > exhaustion/limit > transfer.
// - start while busy is ignored.
// - abort mid-run: generator held in reset next cycle. issued_count keeps its value until the next start.
// - Asserting reset mid-run has the same effect as power-on reset.
// - Single-core build: rr stays 0 and grant=core_ready[0].
// CONFIGURATION
// - SCHED_LIMIT_EN defined:
//   - Adds input port max_count [CNT_W].
//   - In RUN, when issued_count==max_count and max_count!=0, stop granting and go to DRAIN.
//   - max_count is sampled at start; max_count==0 means unlimited.
// - SCHED_LIMIT_EN undefined: port absent; only exhaustion, hit or abort end a run.
// TESTING
// - NUM_CORES=4, all ready, start: grants 0,1,2,3,0 on consecutive cycles, then check chunk ordering.
//   - Prime then RUN: grants cycle 0→1→2→3→0 while all cores stay ready.
//   - Each granted core sees a distinct chunk, in the generator's sequence order.
//   - issued_count=5 after 5 transfers.
// - core_ready=4'b0100 only: grant only core 2; gen_step high only on transfers; gen_chunk stable while
//   ready=0.
// - Generator forced to chunk=0 mid-run, cores idle after 3 cycles: DRAIN then DONE; done=1; no further
//   gen_step.
// - core_hit=4'b1010 in RUN: next cycle found=1, found_core=1, core_valid=0, busy=0.
// - SCHED_LIMIT_EN, max_count=10: exactly 10 transfers, then DONE. abort during RUN → IDLE with
//   gen_rst_n=0 next cycle.
// - reset asserted mid-RUN asynchronously: all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/ntlm_candidate_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ntlm_candidate_scheduler
// Description : Steps the printable-candidate chunk generator and hands each
//               512-bit MD5 chunk to one of NUM_CORES hash cores, round-robin
//               over the ready cores. Detects keyspace exhaustion, drains
//               in-flight work and latches the first core that reports a hit.
//               Optional feature macro: SCHED_LIMIT_EN (adds max_count, a
//               per-run cap on issued candidates; 0 means unlimited).
// Revision    : 1.0 - initial release
// ============================================================================
module ntlm_candidate_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W    = 2,
  parameter int CNT_W     = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 gen_rst_n,
  output logic                 gen_step,
  input  logic [511:0]         gen_chunk,
  output logic [511:0]         core_chunk,
  output logic [NUM_CORES-1:0] core_valid,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_idle,
  input  logic [NUM_CORES-1:0] core_hit,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [CORE_W-1:0]    found_core,
  output logic [CNT_W-1:0]     issued_count
`ifdef SCHED_LIMIT_EN
  ,
  input  logic [CNT_W-1:0]     max_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FOUND = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CORE_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CORE_W-1:0]   found_core_q, found_core_d;
  // A start seen in DONE/FOUND passes through IDLE for one cycle so the
  // generator is reset before PRIME; this flag carries the start across.
  logic                restart_q, restart_d;

  logic                w_grant_found;
  logic [CORE_W-1:0]   w_grant_idx;
  logic [CORE_W:0]     w_cand;
  logic [CORE_W-1:0]   w_hit_idx;
  logic                w_exhaust;
  logic                w_limit;
  logic                w_start_ok;

  assign core_chunk   = gen_chunk;
  assign found_core   = found_core_q;
  assign issued_count = issued_q;

  // The generator wraps to an all-zero chunk after its final candidate.
  assign w_exhaust  = (gen_chunk == '0);
  assign w_start_ok = start & ~abort &
                      ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_FOUND));

`ifdef SCHED_LIMIT_EN
  logic [CNT_W-1:0] limit_q;

  // Capture the run limit at the moment a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_q <= '0;
    end else if (w_start_ok) begin
      limit_q <= max_count;
    end
  end

  assign w_limit = (limit_q != '0) && (issued_q == limit_q);
`else
  assign w_limit = 1'b0;
`endif

  // Round-robin search: first ready core at or above rr, wrapping around.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_cand = {1'b0, rr_q} + (CORE_W+1)'(k);
      if (w_cand >= (CORE_W+1)'(NUM_CORES)) begin
        w_cand = w_cand - (CORE_W+1)'(NUM_CORES);
      end
      if (!w_grant_found && core_ready[w_cand[CORE_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[CORE_W-1:0];
      end
    end
  end

  // Lowest-numbered core reporting a hit this cycle.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (core_hit[i]) begin
        w_hit_idx = CORE_W'(i);
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      issued_q     <= '0;
      found_core_q <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      issued_q     <= issued_d;
      found_core_q <= found_core_d;
      restart_q    <= restart_d;
    end
  end

  // Next-state and output decode; abort outranks hit, hit outranks
  // exhaustion/limit, which outranks a transfer.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    issued_d     = issued_q;
    found_core_d = found_core_q;
    restart_d    = 1'b0;
    gen_rst_n    = 1'b1;
    gen_step     = 1'b0;
    core_valid   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    found        = 1'b0;

    case (state_q)
      S_IDLE: begin
        gen_rst_n = 1'b0;
        if (!abort && (start || restart_q)) begin
          issued_d = '0;
          rr_d     = '0;
          state_d  = S_PRIME;
        end
      end

      S_PRIME: begin
        busy     = 1'b1;
        gen_step = ~abort;
        state_d  = abort ? S_IDLE : S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (|core_hit) begin
          found_core_d = w_hit_idx;
          state_d      = S_FOUND;
        end else if (w_exhaust || w_limit) begin
          state_d = S_DRAIN;
        end else if (w_grant_found) begin
          core_valid = NUM_CORES'(1) << w_grant_idx;
          gen_step   = 1'b1;
          issued_d   = (&issued_q) ? issued_q : issued_q + 1'b1;
          rr_d       = (w_grant_idx == CORE_W'(NUM_CORES-1)) ? '0 : w_grant_idx + 1'b1;
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (|core_hit) begin
          found_core_d = w_hit_idx;
          state_d      = S_FOUND;
        end else if (&core_idle) begin
          state_d = S_DONE;
        end
      end

      S_DONE, S_FOUND: begin
        done  = (state_q == S_DONE);
        found = (state_q == S_FOUND);
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          issued_d  = '0;
          rr_d      = '0;
          restart_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ntlm_candidate_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntlm_candidate_scheduler
// Description : Randomized bench for ntlm_candidate_scheduler with a counting
//               generator model and a run-level reference of the dispatch
//               rules (round-robin order, candidate sequence, end of run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntlm_candidate_scheduler;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CNTW = 48;

  localparam int P_IDLE    = 0;
  localparam int P_RESTART = 1;
  localparam int P_PRIME   = 2;
  localparam int P_RUN     = 3;
  localparam int P_DRAIN   = 4;
  localparam int P_DONE    = 5;
  localparam int P_FOUND   = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic           gen_rst_n;
  logic           gen_step;
  logic [511:0]   gen_chunk;
  logic [511:0]   core_chunk;
  logic [N-1:0]   core_valid;
  logic [N-1:0]   core_ready;
  logic [N-1:0]   core_idle;
  logic [N-1:0]   core_hit;
  logic           busy;
  logic           done;
  logic           found;
  logic [CW-1:0]  found_core;
  logic [CNTW-1:0] issued_count;
`ifdef SCHED_LIMIT_EN
  logic [CNTW-1:0] max_count;
`endif

  int total = 0;
  int bad   = 0;
  int last_phase;

  logic [31:0] gen_k;
  int          gen_last;

  ntlm_candidate_scheduler #(
    .NUM_CORES(N),
    .CORE_W(CW),
    .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .gen_rst_n(gen_rst_n),
    .gen_step(gen_step),
    .gen_chunk(gen_chunk),
    .core_chunk(core_chunk),
    .core_valid(core_valid),
    .core_ready(core_ready),
    .core_idle(core_idle),
    .core_hit(core_hit),
    .busy(busy),
    .done(done),
    .found(found),
    .found_core(found_core),
    .issued_count(issued_count)
`ifdef SCHED_LIMIT_EN
    ,
    .max_count(max_count)
`endif
  );

  always #5 clk = ~clk;

  // Generator model: candidate k (1..gen_last) then wrap to the zero chunk.
  always @(posedge clk) begin
    if (!gen_rst_n) begin
      gen_k <= 32'd0;
    end else if (gen_step) begin
      gen_k <= (gen_k >= 32'(gen_last)) ? 32'd0 : gen_k + 32'd1;
    end
  end

  assign gen_chunk = {16{gen_k}};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int first_ready(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int lowest_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rstn"},   64'(gen_rst_n), 64'(0));
    check_eq({tag, "_step"},   64'(gen_step), 64'(0));
    check_eq({tag, "_valid"},  64'(core_valid), 64'(0));
    check_eq({tag, "_busy"},   64'(busy), 64'(0));
    check_eq({tag, "_done"},   64'(done), 64'(0));
    check_eq({tag, "_found"},  64'(found), 64'(0));
    check_eq({tag, "_fcore"},  64'(found_core), 64'(0));
    check_eq({tag, "_issued"}, 64'(issued_count), 64'(0));
  endtask

  // One run from start to DONE/FOUND/IDLE, checked cycle by cycle.
  // rmode: 0 random ready, 1 all ready, 2 only core 2 (intermittently).
  task automatic run_one(input int last, input int rmode, input int hit_at,
                         input logic [N-1:0] hvec, input int abort_at, input int limit);
    int phase, cyc, m_issued, m_rr, m_fc, drain_cnt, g;
    bit fin;
    logic [N-1:0] r, idl, h;
    logic a;
    gen_last = last;
`ifdef SCHED_LIMIT_EN
    max_count = CNTW'(limit);
`endif
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; core_hit = '0; core_ready = '0; core_idle = '1;
    @(posedge clk); #1;
    start = 1'b0;
    phase = (last_phase == P_DONE || last_phase == P_FOUND) ? P_RESTART : P_PRIME;
    m_issued = 0; m_rr = 0; m_fc = 0; drain_cnt = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      case (rmode)
        0:       r = N'($urandom);
        1:       r = '1;
        default: r = ($urandom_range(0, 1) == 1) ? 4'b0100 : 4'b0000;
      endcase
      idl = (phase == P_DRAIN) ? ((drain_cnt >= 3) ? '1 : '0) : N'($urandom);
      h = ((phase == P_RUN || phase == P_DRAIN) && cyc == hit_at) ? hvec : '0;
      a = (cyc == abort_at) && (phase == P_PRIME || phase == P_RUN || phase == P_DRAIN);
      core_ready = r; core_idle = idl; core_hit = h; abort = a;
      start = (phase == P_RUN) && !a && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      case (phase)
        P_RESTART: begin
          check_eq("rs_busy",   64'(busy), 64'(0));
          check_eq("rs_done",   64'(done), 64'(0));
          check_eq("rs_found",  64'(found), 64'(0));
          check_eq("rs_rstn",   64'(gen_rst_n), 64'(0));
          check_eq("rs_issued", 64'(issued_count), 64'(0));
          phase = P_PRIME;
        end
        P_PRIME: begin
          check_eq("pr_busy",   64'(busy), 64'(1));
          check_eq("pr_rstn",   64'(gen_rst_n), 64'(1));
          check_eq("pr_valid",  64'(core_valid), 64'(0));
          check_eq("pr_issued", 64'(issued_count), 64'(0));
          if (!a) check_eq("pr_step", 64'(gen_step), 64'(1));
          phase = a ? P_IDLE : P_RUN;
        end
        P_RUN: begin
          check_eq("run_busy",   64'(busy), 64'(1));
          check_eq("run_rstn",   64'(gen_rst_n), 64'(1));
          check_eq("run_issued", 64'(issued_count), 64'(m_issued));
          if (a) begin
            check_eq("ab_valid", 64'(core_valid), 64'(0));
            check_eq("ab_step",  64'(gen_step), 64'(0));
            phase = P_IDLE;
          end else if (h != '0) begin
            check_eq("hit_valid", 64'(core_valid), 64'(0));
            check_eq("hit_step",  64'(gen_step), 64'(0));
            m_fc  = lowest_bit(h);
            phase = P_FOUND;
          end else if (gen_chunk == '0) begin
            check_eq("ex_valid", 64'(core_valid), 64'(0));
            check_eq("ex_step",  64'(gen_step), 64'(0));
            check_eq("ex_count", 64'(m_issued), 64'(last));
            phase = P_DRAIN;
          end else if (limit != 0 && m_issued == limit) begin
            check_eq("lim_valid", 64'(core_valid), 64'(0));
            check_eq("lim_step",  64'(gen_step), 64'(0));
            phase = P_DRAIN;
          end else begin
            check_eq("seq",    64'(gen_chunk[31:0]), 64'(m_issued + 1));
            check_eq("bus_eq", 64'(core_chunk == gen_chunk), 64'(1));
            g = first_ready(r, m_rr);
            if (g >= 0) begin
              check_eq("grant", 64'(core_valid), 64'(1) << g);
              check_eq("step",  64'(gen_step), 64'(1));
              m_issued++;
              m_rr = (g + 1) % N;
            end else begin
              check_eq("nogrant", 64'(core_valid), 64'(0));
              check_eq("nostep",  64'(gen_step), 64'(0));
            end
          end
        end
        P_DRAIN: begin
          check_eq("dr_busy",  64'(busy), 64'(1));
          check_eq("dr_valid", 64'(core_valid), 64'(0));
          check_eq("dr_step",  64'(gen_step), 64'(0));
          if (a) phase = P_IDLE;
          else if (h != '0) begin
            m_fc  = lowest_bit(h);
            phase = P_FOUND;
          end else if (idl == '1) phase = P_DONE;
          else drain_cnt++;
        end
        P_DONE: begin
          check_eq("dn_done",   64'(done), 64'(1));
          check_eq("dn_busy",   64'(busy), 64'(0));
          check_eq("dn_found",  64'(found), 64'(0));
          check_eq("dn_step",   64'(gen_step), 64'(0));
          check_eq("dn_valid",  64'(core_valid), 64'(0));
          check_eq("dn_issued", 64'(issued_count), 64'((limit != 0) ? limit : last));
          fin = 1'b1;
        end
        P_FOUND: begin
          check_eq("fd_found", 64'(found), 64'(1));
          check_eq("fd_core",  64'(found_core), 64'(m_fc));
          check_eq("fd_busy",  64'(busy), 64'(0));
          check_eq("fd_done",  64'(done), 64'(0));
          check_eq("fd_valid", 64'(core_valid), 64'(0));
          check_eq("fd_step",  64'(gen_step), 64'(0));
          check_eq("fd_issued", 64'(issued_count), 64'(m_issued));
          fin = 1'b1;
        end
        default: begin
          check_eq("id_rstn",   64'(gen_rst_n), 64'(0));
          check_eq("id_busy",   64'(busy), 64'(0));
          check_eq("id_valid",  64'(core_valid), 64'(0));
          check_eq("id_step",   64'(gen_step), 64'(0));
          check_eq("id_issued", 64'(issued_count), 64'(m_issued));
          fin = 1'b1;
        end
      endcase
      if (fin) begin
        last_phase = phase;
      end else if (cyc >= 400) begin
        check_eq("budget_phase", 64'(phase), 64'(P_DONE));
        fin = 1'b1;
        last_phase = phase;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic reset_midrun();
    gen_last = 50;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; core_hit = '0; core_ready = '1; core_idle = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check_eq("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    last_phase = P_IDLE;
    check_reset_vals("post_rst");
  endtask

  initial begin
    int last, hit_at, abort_at, rmode;
    logic [N-1:0] hvec;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    core_ready = '0; core_idle = '1; core_hit = '0;
    gen_last = 8;
`ifdef SCHED_LIMIT_EN
    max_count = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    last_phase = P_IDLE;
    @(posedge clk); #1;
    check_eq("idle_rstn", 64'(gen_rst_n), 64'(0));
    check_eq("idle_busy", 64'(busy), 64'(0));

    run_one(8, 1, -1, '0, -1, 0);
    run_one(6, 2, -1, '0, -1, 0);
    run_one(5, 1, 4, 4'b1010, -1, 0);
    run_one(20, 1, -1, '0, 5, 0);
`ifdef SCHED_LIMIT_EN
    run_one(30, 0, -1, '0, -1, 10);
`endif
    for (int t = 0; t < 14; t++) begin
      last     = $urandom_range(3, 25);
      rmode    = $urandom_range(0, 2);
      hit_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : -1;
      hvec     = N'($urandom_range(1, 15));
      abort_at = (hit_at < 0 && $urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1;
      run_one(last, rmode, hit_at, hvec, abort_at, 0);
    end
    reset_midrun();
    run_one(7, 0, -1, '0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
